// File: rtl/slot_pkg.sv
// Shared types for the slot-machine FPGA/MCU status link: the frame layout and the
// states of the SPI status transmitter.
package slot_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int CREDIT_W    = 12;

  typedef struct packed {
    logic                done;
    logic                spinning;
    logic [1:0]          state;
    logic [CREDIT_W-1:0] credits;
  } status_frame_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    WAIT
  } spi_tx_state_t;

endpackage

// File: rtl/spi_status_tx_sync_edge.sv
// Synchronizer for one slow asynchronous input, plus single-cycle rise/fall pulses
// derived from the synchronized level.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state always uses non-blocking assignments; blocking assignments
  // here would let simulation order decide whether the chain shifts by one or many.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_status_tx.sv
// SPI mode-0 status transmitter: snapshots the status frame on cs fall and shifts it
// out MSB first on sdo. Define SPI_TX_PARITY_EN to append an even-parity bit.
module spi_status_tx
  import slot_pkg::*;
#(
  parameter int FRAME_W     = SPI_FRAME_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sclk,
  input  logic                cs,
  output logic                sdo,
  input  logic                done_in,
  input  logic                spinning_in,
  input  logic [1:0]          state_in,
  input  logic [CREDIT_W-1:0] credits_in,
  output logic                frame_sent,
  output logic                busy
);

`ifdef SPI_TX_PARITY_EN
  localparam int TOTAL_W = FRAME_W + 1;
`else
  localparam int TOTAL_W = FRAME_W;
`endif
  localparam int CNT_W = $clog2(TOTAL_W + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset_n(reset_n), .d(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset_n(reset_n), .d(cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_tx_state_t       state_q, state_d;
  logic [TOTAL_W-1:0]  shreg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                snap_done_q;
  logic                done_sticky_q;
  status_frame_t       status;
  logic [FRAME_W-1:0]  frame;
  logic [TOTAL_W-1:0]  load_word;
  logic                bit_rise, bit_fall;

  // sclk only counts while the MCU is actually selecting us
  assign bit_rise = sclk_rise & ~cs_level;
  assign bit_fall = sclk_fall & ~cs_level;

  always_comb begin
    status.done     = done_sticky_q;
    status.spinning = spinning_in;
    status.state    = state_in;
    status.credits  = credits_in;
    frame           = '0;
    frame[FRAME_W-1 -: $bits(status_frame_t)] = status;
`ifdef SPI_TX_PARITY_EN
    load_word = {frame, ^frame};
`else
    load_word = frame;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (cs_rise)                                     state_d = IDLE;
        else if (bit_rise && cnt_q == CNT_W'(TOTAL_W-1)) state_d = DONE;
      end
      DONE:  state_d = cs_rise ? IDLE : WAIT;
      WAIT:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sdo        = 1'b0;
    frame_sent = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      IDLE:  if (cs_fall) sdo = load_word[TOTAL_W-1];
      SHIFT: begin
        sdo  = cs_rise ? 1'b0 : shreg_q[TOTAL_W-1];
        busy = 1'b1;
      end
      DONE: begin
        frame_sent = 1'b1;
        busy       = 1'b1;
      end
      WAIT:  busy = 1'b1;
      default: ;
    endcase
  end

  // The snapshot stays frozen in shreg_q until the next cs fall in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      snap_done_q <= 1'b0;
    end else if (state_q == IDLE && cs_fall) begin
      shreg_q     <= load_word;
      cnt_q       <= '0;
      snap_done_q <= status.done;
    end else if (state_q == SHIFT && !cs_rise) begin
      if (bit_rise) cnt_q <= cnt_q + 1'b1;
      if (bit_fall && cnt_q < CNT_W'(TOTAL_W)) shreg_q <= shreg_q << 1;
    end
  end

  // A fresh done pulse outranks clearing the one that was just reported.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       done_sticky_q <= 1'b0;
    else if (done_in)                   done_sticky_q <= 1'b1;
    else if (frame_sent && snap_done_q) done_sticky_q <= 1'b0;
  end

endmodule

// File: tb/tb_spi_status_tx.sv
// Self-checking bench for spi_status_tx: an MCU model clocks mode-0 frames at clk/10
// and compares captured bits against a scoreboard of expected snapshots.
module tb_spi_status_tx;
  import slot_pkg::*;

  localparam int FRAME_W = 16;
  localparam int SYNC_STAGES = 2;
`ifdef SPI_TX_PARITY_EN
  localparam int TOT = FRAME_W + 1;
`else
  localparam int TOT = FRAME_W;
`endif

  logic clk = 1'b0;
  logic reset_n, sclk, cs, sdo, done_in, spinning_in, frame_sent, busy;
  logic [1:0]  state_in;
  logic [11:0] credits_in;

  int checks = 0;
  int failures = 0;
  int sent_cnt = 0;

  logic [TOT-1:0] exp_q[$];

  typedef struct {
    bit          do_done;
    logic        sp;
    logic [1:0]  st;
    logic [11:0] cr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  spi_status_tx #(.FRAME_W(FRAME_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs(cs), .sdo(sdo),
    .done_in(done_in), .spinning_in(spinning_in), .state_in(state_in),
    .credits_in(credits_in), .frame_sent(frame_sent), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_sent === 1'b1) sent_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [TOT-1:0] tot_bits(input logic [15:0] f);
`ifdef SPI_TX_PARITY_EN
    return {f, ^f};
`else
    return f;
`endif
  endfunction

  task automatic pulse_done();
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    @(negedge clk);
  endtask

  // abort_after>0 raises cs after that many sclk periods; change_after>=0 rewrites
  // credits mid-frame; done_at_end pulses done_in in the frame_sent cycle.
  task automatic run_frame(input int abort_after, input int change_after,
                           input bit done_at_end, input string name);
    logic [TOT-1:0] rx = '0;
    logic [TOT-1:0] exp;
    int sent_before = sent_cnt;
    int nb = (abort_after > 0) ? abort_after : TOT;
    int k;
    cs = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      if (i == change_after) credits_in = 12'hFFF;
      if (i == nb - 1 && abort_after == 0)
        check({name, " no early frame_sent"}, sent_cnt, sent_before);
      rx = {rx[TOT-2:0], sdo};
      sclk = 1'b1;
      if (i == nb - 1 && done_at_end) begin
        k = 0;
        while (frame_sent !== 1'b1 && k < 12) begin
          @(negedge clk);
          k++;
        end
        check({name, " frame_sent seen"}, frame_sent, 1'b1);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      if (i == 3) check({name, " busy mid-frame"}, busy, 1'b1);
      sclk = 1'b0;
      repeat (5) @(negedge clk);
    end
    if (abort_after > 0) begin
      cs = 1'b1;
      repeat (SYNC_STAGES + 2) @(negedge clk);
      check({name, " busy after abort"}, busy, 1'b0);
      repeat (10) @(negedge clk);
      check({name, " no frame_sent on abort"}, sent_cnt, sent_before);
    end else begin
      check({name, " one frame_sent"}, sent_cnt, sent_before + 1);
      for (int j = 0; j < 2; j++) begin
        check({name, " sdo idle on extra sclk"}, sdo, 1'b0);
        sclk = 1'b1;
        repeat (5) @(negedge clk);
        sclk = 1'b0;
        repeat (5) @(negedge clk);
      end
      check({name, " busy in WAIT"}, busy, 1'b1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s scoreboard empty", name);
      end else begin
        exp = exp_q.pop_front();
        check({name, " frame bits"}, rx, exp);
      end
      cs = 1'b1;
      repeat (10) @(negedge clk);
      check({name, " busy after cs rise"}, busy, 1'b0);
      check({name, " single frame_sent"}, sent_cnt, sent_before + 1);
    end
  endtask

  task automatic set_inputs(input logic sp, input logic [1:0] st, input logic [11:0] cr);
    spinning_in = sp;
    state_in    = st;
    credits_in  = cr;
  endtask

  initial begin
    logic sdo_seen;
    vecs[0] = '{1'b1, 1'b0, 2'b10, 12'h0A5, 16'hA0A5};
    vecs[1] = '{1'b0, 1'b0, 2'b10, 12'h0A5, 16'h20A5};
    vecs[2] = '{1'b0, 1'b1, 2'b01, 12'h123, 16'h5123};
    vecs[3] = '{1'b1, 1'b1, 2'b11, 12'hFFF, 16'hFFFF};
    vecs[4] = '{1'b0, 1'b0, 2'b00, 12'h000, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 2'b00, 12'h003, 16'h0003};
    vecs[6] = '{1'b0, 1'b0, 2'b00, 12'h001, 16'h0001};

    reset_n = 1'b0;
    cs = 1'b1;
    sclk = 1'b0;
    done_in = 1'b0;
    set_inputs(1'b0, 2'b00, 12'h000);
    repeat (4) @(negedge clk);
    check("reset sdo", sdo, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset frame_sent", frame_sent, 1'b0);
    reset_n = 1'b1;

    // cs held high: sclk activity must not start anything
    sdo_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sclk = 1'b1;
      repeat (5) begin
        @(negedge clk);
        sdo_seen |= sdo;
      end
      sclk = 1'b0;
      repeat (5) begin
        @(negedge clk);
        sdo_seen |= sdo;
      end
    end
    check("cs high sdo quiet", sdo_seen, 1'b0);
    check("cs high busy", busy, 1'b0);
    check("cs high no frame_sent", sent_cnt, 0);

    for (int v = 0; v < 7; v++) begin
      set_inputs(vecs[v].sp, vecs[v].st, vecs[v].cr);
      if (vecs[v].do_done) pulse_done();
      exp_q.push_back(tot_bits(vecs[v].exp));
      run_frame(0, -1, 1'b0, $sformatf("vec%0d", v));
    end

    set_inputs(1'b0, 2'b10, 12'h0A5);
    exp_q.push_back(tot_bits(16'h20A5));
    run_frame(0, 8, 1'b0, "midchange");

    set_inputs(1'b0, 2'b10, 12'h0A5);
    pulse_done();
    run_frame(5, -1, 1'b0, "abort");
    exp_q.push_back(tot_bits(16'hA0A5));
    run_frame(0, -1, 1'b0, "after_abort");

    pulse_done();
    exp_q.push_back(tot_bits(16'hA0A5));
    run_frame(0, -1, 1'b1, "coincide");
    exp_q.push_back(tot_bits(16'hA0A5));
    run_frame(0, -1, 1'b0, "coincide_next");
    exp_q.push_back(tot_bits(16'h20A5));
    run_frame(0, -1, 1'b0, "cleared");

    // asynchronous reset in the middle of a frame
    pulse_done();
    cs = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("pre-reset busy", busy, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check("async reset busy", busy, 1'b0);
    check("async reset sdo", sdo, 1'b0);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(tot_bits(16'h20A5));
    run_frame(0, -1, 1'b0, "post_reset");

    check("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
